// File: rtl/sig_arb_pkg.sv
// -----------------------------------------------------------------------------
// sig_arb_pkg
// Shared definitions for the sigmoid-ROM arbiter and future arbiters that need
// a rotating-priority search (for example weight-memory arbiters).
//   PERF_CNT_W    : width of the optional performance counters
//   MAX_REQ       : widest requester vector the helper functions handle
//   onehot_to_idx : index of the set bit of a one-hot vector (0 if none)
//   rr_search     : rotate-priority search returning a one-hot grant
// -----------------------------------------------------------------------------
package sig_arb_pkg;

  localparam int PERF_CNT_W = 32;
  localparam int MAX_REQ    = 16;

  // Index of the set bit in a one-hot vector; an all-zero vector maps to 0.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = i;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // First set bit of req at or after position ptr, wrapping modulo n.
  // Only the low n bits of req take part; the result is one-hot or zero.
  function automatic logic [MAX_REQ-1:0] rr_search(input logic [MAX_REQ-1:0] req,
                                                   input int n,
                                                   input int ptr);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    logic [3:0]         pos;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      pos = 4'((ptr + k) % n);
      if ((k < n) && !found && req[pos]) begin
        gnt[pos] = 1'b1;
        found    = 1'b1;
      end else begin
        found = found;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr and wraps
// modulo NUM_REQ; the first active request wins.
// Ports:
//   req [NUM_REQ-1:0] : active requests
//   ptr [IDX_W-1:0]   : highest-priority index this cycle (must be < NUM_REQ)
//   gnt [NUM_REQ-1:0] : one-hot grant, zero when no request is active
//   idx [IDX_W-1:0]   : binary index of the grant (0 when gnt is zero)
// -----------------------------------------------------------------------------
module rr_arbiter
  import sig_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  logic [MAX_REQ-1:0] req_ext_s;
  logic [MAX_REQ-1:0] gnt_ext_s;

  // Widen the request vector to the helper width, search, and narrow back.
  always_comb begin
    req_ext_s                = '0;
    req_ext_s[NUM_REQ-1:0]   = req;
    gnt_ext_s                = rr_search(req_ext_s, NUM_REQ, int'(ptr));
    gnt                      = gnt_ext_s[NUM_REQ-1:0];
    idx                      = IDX_W'(onehot_to_idx(gnt_ext_s));
  end

endmodule

// File: rtl/sig_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sig_rom_arbiter
// Shares one sigmoid lookup ROM among NUM_REQ neuron requesters. At most one
// lookup is granted per cycle (round robin), its operand is driven to the ROM,
// and the looked-up value is returned ROM_LAT+1 cycles after the grant with a
// one-hot response strobe naming the requester.
//
// Build option: define SIG_ARB_PERF_EN to add saturating 32-bit counters
// perf_grants (grants issued) and perf_conflicts (cycles with two or more
// requests). Without the macro those ports and counters do not exist.
//
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   req_valid[N]   : per-requester lookup request
//   req_x[N*IW]    : packed operands, requester i at [i*IN_WIDTH +: IN_WIDTH]
//   req_ready[N]   : one-hot grant; transfer when req_valid[i] && req_ready[i]
//   rom_x[IW]      : operand to the ROM (0 when nothing is granted)
//   rom_out[DW]    : ROM data, valid ROM_LAT cycles after rom_x is sampled
//   rsp_valid[N]   : one-hot one-cycle response strobe
//   rsp_data[DW]   : response value, qualified by rsp_valid
//   perf_grants, perf_conflicts : optional performance counters
// -----------------------------------------------------------------------------
module sig_rom_arbiter
  import sig_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IN_WIDTH   = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ROM_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*IN_WIDTH-1:0]   req_x,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [IN_WIDTH-1:0]           rom_x,
  input  logic [DATA_WIDTH-1:0]         rom_out,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data
`ifdef SIG_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0]         perf_grants,
  output logic [PERF_CNT_W-1:0]         perf_conflicts
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer: index with highest priority this cycle.
  logic [IDX_W-1:0]                 ptr_q, ptr_d;

  // ROM latency pipeline: valid bit plus one-hot requester tag per stage.
  logic [ROM_LAT-1:0]               pipe_vld_q, pipe_vld_d;
  logic [ROM_LAT-1:0][NUM_REQ-1:0]  pipe_tag_q, pipe_tag_d;

  // Registered response.
  logic [NUM_REQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]            rsp_data_q, rsp_data_d;

  logic [NUM_REQ-1:0]               req_act_s;
  logic [NUM_REQ-1:0]               gnt_s;
  logic [IDX_W-1:0]                 gnt_idx_s;
  logic                             gnt_any_s;
  logic [IN_WIDTH-1:0]              rom_x_s;

  // Requests are masked while reset is asserted so no grant can leak out.
  always_comb begin
    if (rst_n) begin
      req_act_s = req_valid;
    end else begin
      req_act_s = '0;
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req (req_act_s),
    .ptr (ptr_q),
    .gnt (gnt_s),
    .idx (gnt_idx_s)
  );

  // One-hot AND-OR mux of the winner's operand; yields 0 with no grant.
  always_comb begin
    gnt_any_s = |gnt_s;
    rom_x_s   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_s[i]) begin
        rom_x_s = rom_x_s | req_x[i*IN_WIDTH +: IN_WIDTH];
      end else begin
        rom_x_s = rom_x_s;
      end
    end
  end

  assign req_ready = gnt_s;
  assign rom_x     = rom_x_s;

  // Pointer moves to the slot after the winner; it holds when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any_s) begin
      if (int'(gnt_idx_s) == NUM_REQ - 1) begin
        ptr_d = '0;
      end else begin
        ptr_d = gnt_idx_s + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Stage 0 captures the grant; later stages shift it toward the ROM output.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_tag_d    = '0;
    pipe_vld_d[0] = gnt_any_s;
    pipe_tag_d[0] = gnt_s;
    for (int k = 1; k < ROM_LAT; k++) begin
      pipe_vld_d[k] = pipe_vld_q[k-1];
      pipe_tag_d[k] = pipe_tag_q[k-1];
    end
  end

  // When the last stage is valid the ROM data belongs to its tag; otherwise
  // the strobe drops and the data register keeps its last value.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pipe_vld_q[ROM_LAT-1]) begin
      rsp_valid_d = pipe_tag_q[ROM_LAT-1];
      rsp_data_d  = rom_out;
    end else begin
      rsp_valid_d = '0;
      rsp_data_d  = rsp_data_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      pipe_vld_q  <= '0;
      pipe_tag_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_tag_q  <= pipe_tag_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

`ifdef SIG_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] perf_grants_q, perf_grants_d;
  logic [PERF_CNT_W-1:0] perf_conflicts_q, perf_conflicts_d;
  logic                  multi_req_s;

  // x & (x-1) clears the lowest set bit, so a nonzero result means >= 2 bits.
  always_comb begin
    multi_req_s      = |(req_valid & (req_valid - NUM_REQ'(1)));
    perf_grants_d    = perf_grants_q;
    perf_conflicts_d = perf_conflicts_q;
    if (gnt_any_s && (perf_grants_q != {PERF_CNT_W{1'b1}})) begin
      perf_grants_d = perf_grants_q + PERF_CNT_W'(1);
    end else begin
      perf_grants_d = perf_grants_q;
    end
    if (multi_req_s && (perf_conflicts_q != {PERF_CNT_W{1'b1}})) begin
      perf_conflicts_d = perf_conflicts_q + PERF_CNT_W'(1);
    end else begin
      perf_conflicts_d = perf_conflicts_q;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_grants_q    <= '0;
      perf_conflicts_q <= '0;
    end else begin
      perf_grants_q    <= perf_grants_d;
      perf_conflicts_q <= perf_conflicts_d;
    end
  end

  assign perf_grants    = perf_grants_q;
  assign perf_conflicts = perf_conflicts_q;
`endif

endmodule

// File: tb/tb_sig_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sig_rom_arbiter
// Self-checking bench for sig_rom_arbiter with a registered ROM model
// (latency 1, mem[i] = i + 16'h100, index = x offset by 512). Expected values
// come from a behavioural model: a rotating priority pointer and a queue of
// pending responses stamped with the cycle they are due.
// -----------------------------------------------------------------------------
module tb_sig_rom_arbiter;

  localparam int N  = 4;
  localparam int XW = 10;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*XW-1:0]   req_x;
  logic [N-1:0]      req_ready;
  logic [XW-1:0]     rom_x;
  logic [DW-1:0]     rom_out;
  logic [N-1:0]      rsp_valid;
  logic [DW-1:0]     rsp_data;
`ifdef SIG_ARB_PERF_EN
  logic [31:0]       perf_grants;
  logic [31:0]       perf_conflicts;
`endif

  sig_rom_arbiter #(
    .NUM_REQ    (N),
    .IN_WIDTH   (XW),
    .DATA_WIDTH (DW),
    .ROM_LAT    (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rom_x     (rom_x),
    .rom_out   (rom_out),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
`ifdef SIG_ARB_PERF_EN
    ,
    .perf_grants    (perf_grants),
    .perf_conflicts (perf_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // ROM environment: registers the offset index, data follows the register.
  logic [XW-1:0] rom_idx_q;
  always @(posedge clk) rom_idx_q <= rom_x ^ 10'h200;
  assign rom_out = 16'h0100 + {6'b0, rom_idx_q};

  // ---------------------------------------------------------------- model
  typedef struct {
    int          due;
    int          who;
    logic [15:0] val;
  } rsp_t;

  rsp_t        pend[$];
  int          m_ptr;
  int          m_cyc;
  logic [15:0] m_data;
  logic [N-1:0]  exp_rdy;
  logic [XW-1:0] exp_rx;
  logic [N-1:0]  exp_rv;
  logic [DW-1:0] exp_rd;
  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] ref_rom(input logic [XW-1:0] x);
    int i;
    i = (int'(x) + 512) % 1024;
    return 16'(i + 256);
  endfunction

  function automatic int ref_winner(input logic [N-1:0] rv, input int p);
    for (int k = 0; k < N; k++) begin
      if (rv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Let combinational outputs settle and compute this cycle's expectations.
  task automatic settle();
    int w;
    #1;
    w = rst_n ? ref_winner(req_valid, m_ptr) : -1;
    exp_rdy = (w >= 0) ? N'(1 << w) : '0;
    exp_rx  = (w >= 0) ? req_x[w*XW +: XW] : '0;
    if (pend.size() > 0 && pend[0].due == m_cyc) begin
      exp_rv = N'(1 << pend[0].who);
      exp_rd = pend[0].val;
    end else begin
      exp_rv = '0;
      exp_rd = m_data;
    end
  endtask

  // Advance the model across the coming edge, then move to the next negedge.
  task automatic tick();
    int   w;
    rsp_t r;
    if (!rst_n) begin
      pend.delete();
      m_ptr  = 0;
      m_data = '0;
    end else begin
      if (pend.size() > 0 && pend[0].due == m_cyc) begin
        m_data = pend[0].val;
        void'(pend.pop_front());
      end
      w = ref_winner(req_valid, m_ptr);
      if (w >= 0) begin
        r.due = m_cyc + 2;
        r.who = w;
        r.val = ref_rom(req_x[w*XW +: XW]);
        pend.push_back(r);
        m_ptr = (w + 1) % N;
      end
    end
    m_cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    req_x[2*XW +: XW] = 10'h005;
    req_valid = 4'b0100;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL reset_pre_grant got=%b exp=%b", req_ready, 4'b0100);
    end
    tick();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    settle();
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL reset_ready_forced got=%b exp=0000", req_ready);
    end
    checks++;
    if (rom_x !== 10'h000) begin
      errors++; $display("FAIL reset_rom_x got=%h exp=000", rom_x);
    end
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (rsp_valid !== 4'b0000) begin
        errors++; $display("FAIL reset_no_rsp c=%0d got=%b exp=0000", c, rsp_valid);
      end
      checks++;
      if (rsp_data !== 16'h0000) begin
        errors++; $display("FAIL reset_rsp_data c=%0d got=%h exp=0000", c, rsp_data);
      end
      tick();
    end
  endtask

  task automatic test_single();
    logic [N-1:0]  v_tab [3] = '{4'b0001, 4'b0000, 4'b0000};
    logic [N-1:0]  rv_tab[3] = '{4'b0000, 4'b0000, 4'b0001};
    req_x[0 +: XW] = 10'h000;
    for (int c = 0; c < 3; c++) begin
      req_valid = v_tab[c];
      settle();
      checks++;
      if (req_ready !== v_tab[c] || req_ready !== exp_rdy) begin
        errors++; $display("FAIL single_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
      end
      checks++;
      if (rom_x !== 10'h000) begin
        errors++; $display("FAIL single_rom_x c=%0d got=%h exp=000", c, rom_x);
      end
      checks++;
      if (rsp_valid !== rv_tab[c] || rsp_valid !== exp_rv) begin
        errors++; $display("FAIL single_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, rv_tab[c]);
      end
      if (c == 2) begin
        checks++;
        if (rsp_data !== 16'h0300 || rsp_data !== exp_rd) begin
          errors++; $display("FAIL single_rsp_data got=%h exp=%h", rsp_data, exp_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < N; i++) req_x[i*XW +: XW] = XW'(i + 1);
    for (int c = 0; c < 13; c++) begin
      req_valid = (c < 10) ? 4'b1111 : 4'b0000;
      settle();
      checks++;
      if (c < 10 && req_ready !== N'(1 << (c % N))) begin
        errors++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, req_ready, N'(1 << (c % N)));
      end
      checks++;
      if (req_ready !== exp_rdy || rom_x !== exp_rx) begin
        errors++; $display("FAIL rr_grant c=%0d got=%b/%h exp=%b/%h", c, req_ready, rom_x, exp_rdy, exp_rx);
      end
      checks++;
      if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
        errors++; $display("FAIL rr_rsp c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_data, exp_rv, exp_rd);
      end
      tick();
    end
  endtask

  task automatic test_ptr_wrap();
    logic [N-1:0] v_tab[6] = '{4'b0100, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 4'b0000};
    logic [N-1:0] g_tab[6] = '{4'b0100, 4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b0000};
    for (int c = 0; c < 6; c++) begin
      req_valid = v_tab[c];
      settle();
      checks++;
      if (req_ready !== g_tab[c] || req_ready !== exp_rdy) begin
        errors++; $display("FAIL wrap_grant c=%0d got=%b exp=%b", c, req_ready, g_tab[c]);
      end
      checks++;
      if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
        errors++; $display("FAIL wrap_rsp c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_data, exp_rv, exp_rd);
      end
      tick();
    end
  endtask

  task automatic test_sign_boundary();
    logic [N-1:0]  v_tab [4] = '{4'b0110, 4'b0100, 4'b0000, 4'b0000};
    logic [XW-1:0] x_tab [4] = '{10'h1FF, 10'h200, 10'h000, 10'h000};
    logic [N-1:0]  rv_tab[4] = '{4'b0000, 4'b0000, 4'b0010, 4'b0100};
    logic [DW-1:0] rd_tab[4] = '{16'h0000, 16'h0000, 16'h04FF, 16'h0100};
    req_x[1*XW +: XW] = 10'h1FF;
    req_x[2*XW +: XW] = 10'h200;
    for (int c = 0; c < 4; c++) begin
      req_valid = v_tab[c];
      settle();
      checks++;
      if (rom_x !== x_tab[c] || rom_x !== exp_rx) begin
        errors++; $display("FAIL sign_rom_x c=%0d got=%h exp=%h", c, rom_x, x_tab[c]);
      end
      checks++;
      if (rsp_valid !== rv_tab[c] || rsp_valid !== exp_rv) begin
        errors++; $display("FAIL sign_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, rv_tab[c]);
      end
      if (c >= 2) begin
        checks++;
        if (rsp_data !== rd_tab[c] || rsp_data !== exp_rd) begin
          errors++; $display("FAIL sign_rsp_data c=%0d got=%h exp=%h", c, rsp_data, rd_tab[c]);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] granted;
    granted   = '0;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || granted[i]) begin
          req_valid[i] = ($urandom_range(99, 0) < 55);
          if (req_valid[i]) req_x[i*XW +: XW] = XW'($urandom);
        end else if ($urandom_range(99, 0) < 5) begin
          req_valid[i] = 1'b0;
        end
      end
      settle();
      granted = exp_rdy;
      checks++;
      if (req_ready !== exp_rdy || rom_x !== exp_rx) begin
        errors++; $display("FAIL rand_grant c=%0d got=%b/%h exp=%b/%h", c, req_ready, rom_x, exp_rdy, exp_rx);
      end
      checks++;
      if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
        errors++; $display("FAIL rand_rsp c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_data, exp_rv, exp_rd);
      end
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++;
      if (rsp_valid !== exp_rv || rsp_data !== exp_rd) begin
        errors++; $display("FAIL rand_drain c=%0d got=%b/%h exp=%b/%h", c, rsp_valid, rsp_data, exp_rv, exp_rd);
      end
      tick();
    end
  endtask

`ifdef SIG_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < N; i++) req_x[i*XW +: XW] = XW'($urandom);
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      settle();
      tick();
    end
    settle();
    checks++;
    if (perf_grants !== 32'd8) begin
      errors++; $display("FAIL perf_grants got=%0d exp=8", perf_grants);
    end
    checks++;
    if (perf_conflicts !== 32'd8) begin
      errors++; $display("FAIL perf_conflicts got=%0d exp=8", perf_conflicts);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    m_ptr     = 0;
    m_cyc     = 0;
    m_data    = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_sign_boundary();
    test_random();
`ifdef SIG_ARB_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
